// File: rtl/attn_pkg.sv
// Shared types and score reduction for the attention Q.K scheduler.
// ATTN_SCORE_SAT_EN selects the saturating Q2.14 -> Q1.6 reduction.
package attn_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 17;

  typedef enum logic [1:0] {
    GET_Q,
    GET_K,
    WAIT_ACC,
    SEND
  } state_e;

  function automatic logic [DATA_W-1:0] reduce(
    input logic [ACC_W-1:0] acc
  );
`ifdef ATTN_SCORE_SAT_EN
    if (acc[16] != acc[15]) begin
      reduce = acc[16] ? 8'h80 : 8'h7F;
    end else begin
      reduce = acc[15:8];
    end
`else
    reduce = acc[16:9];
`endif
  endfunction

endpackage

// File: rtl/attn_credit_counter.sv
// Downstream credit pool: one credit per score sent, one per return.
// Returns at a full pool are dropped and flagged in a sticky error.
module attn_credit_counter #(
  parameter int CREDITS = 2,
  parameter int CW      = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          consume_i,
  input  logic          ret_i,
  output logic [CW-1:0] credits_o,
  output logic          err_o
);

  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Next credit count; simultaneous send and return cancel out.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case ({consume_i, ret_i})
      2'b10: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      2'b01: begin
        if (cnt_q == FULL) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Credit and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= FULL;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign credits_o = cnt_q;
  assign err_o     = err_q;

endmodule

// File: rtl/attn_score_scheduler.sv
// Sequences Q/K bytes into the external MAC and ships reduced scores.
// ATTN_SCORE_SAT_EN (see attn_pkg) selects saturating reduction.
module attn_score_scheduler
  import attn_pkg::*;
#(
  parameter int NUM_FEATURES = 4,
  parameter int CREDITS      = 2,
  parameter int CW           = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_en,
  output logic              mac_clr,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic [DATA_W-1:0] out_score,
  output logic              out_vld,
  input  logic              credit_ret,
  output logic [CW-1:0]     credits,
  output logic              credit_err
);

  localparam int FW =
    (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [FW-1:0] LAST = FW'(NUM_FEATURES - 1);

  state_e            state_q;
  logic [FW-1:0]     feat_q;
  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] score_q;
  logic              vld_q;
  logic              boot_q;
  logic              send;

  assign in_rdy = (state_q == GET_Q) || (state_q == GET_K);
  assign send   = (state_q == SEND) && (credits != '0);

  assign mac_a  = q_q;
  assign mac_b  = in_data;
  assign mac_en = (state_q == GET_K) && in_vld;

  // The external MAC keeps its sum across our reset, so the first
  // cycle after reset wipes any partial score it still holds.
  assign mac_clr = rst_n && (boot_q || send);

  assign out_score = score_q;
  assign out_vld   = vld_q;

  // Score sequencer with registered score and send pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GET_Q;
      feat_q  <= '0;
      q_q     <= '0;
      score_q <= '0;
      vld_q   <= 1'b0;
      boot_q  <= 1'b1;
    end else begin
      boot_q <= 1'b0;
      vld_q  <= 1'b0;
      unique case (state_q)
        GET_Q: begin
          if (in_vld) begin
            q_q     <= in_data;
            state_q <= GET_K;
          end
        end
        GET_K: begin
          if (in_vld) begin
            if (feat_q == LAST) begin
              feat_q  <= '0;
              state_q <= WAIT_ACC;
            end else begin
              feat_q  <= feat_q + 1'b1;
              state_q <= GET_Q;
            end
          end
        end
        WAIT_ACC: begin
          state_q <= SEND;
        end
        SEND: begin
          if (send) begin
            score_q <= reduce(mac_acc);
            vld_q   <= 1'b1;
            state_q <= GET_Q;
          end
        end
        default: begin
          state_q <= GET_Q;
        end
      endcase
    end
  end

  attn_credit_counter #(
    .CREDITS (CREDITS),
    .CW      (CW)
  ) u_credit (
    .clk       (clk),
    .rst_n     (rst_n),
    .consume_i (send),
    .ret_i     (credit_ret),
    .credits_o (credits),
    .err_o     (credit_err)
  );

endmodule

// File: tb/tb_attn_score_scheduler.sv
// Bench for attn_score_scheduler: MAC stand-in, cycle model, directed runs.
// Literal score expectations follow ATTN_SCORE_SAT_EN.
module tb_attn_score_scheduler;

  localparam int NF = 4;
  localparam int CR = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_vld;
  logic        in_rdy;
  logic [7:0]  mac_a, mac_b;
  logic        mac_en, mac_clr;
  logic signed [16:0] mac_acc;
  logic [7:0]  out_score;
  logic        out_vld;
  logic        credit_ret;
  logic [1:0]  credits;
  logic        credit_err;

  attn_score_scheduler #(
    .NUM_FEATURES (NF),
    .CREDITS      (CR),
    .CW           (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_en     (mac_en),
    .mac_clr    (mac_clr),
    .mac_acc    (mac_acc),
    .out_score  (out_score),
    .out_vld    (out_vld),
    .credit_ret (credit_ret),
    .credits    (credits),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_k_cyc = 0;
  logic [7:0] got[$];
  int got_cyc[$];

  always @(posedge clk) cyc++;

  // External MAC: not reset by rst_n, only by mac_clr.
  initial mac_acc = '0;
  always @(posedge clk) begin
    if (mac_clr) mac_acc <= '0;
    else if (mac_en)
      mac_acc <= mac_acc + 17'($signed(mac_a) * $signed(mac_b));
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Score from a plain integer sum held in a 17-bit accumulator.
  function automatic int model_score(input int s);
    int w;
    w = s & 'h1FFFF;
    if (w >= 65536) w -= 131072;
`ifdef ATTN_SCORE_SAT_EN
    if (w > 32767) return 'h7F;
    if (w < -32768) return 'h80;
    return (w >>> 8) & 'hFF;
`else
    return (w >>> 9) & 'hFF;
`endif
  endfunction

  // Protocol model
  int   m_q, m_sum, m_psum, m_cnt, m_wt, m_cred, m_score;
  bit   m_half, m_pend, m_err, m_vld, m_clr;

  always @(negedge clk) begin
    bit snd, p0;
    if (!rst_n) begin
      chk("rst_vld", out_vld, 0);
      chk("rst_score", out_score, 0);
      chk("rst_cred", credits, CR);
      chk("rst_err", credit_err, 0);
      chk("rst_rdy", in_rdy, 1);
      chk("rst_clr", mac_clr, 0);
      m_q = 0; m_sum = 0; m_psum = 0; m_cnt = 0; m_wt = 0;
      m_cred = CR; m_score = 0;
      m_half = 0; m_pend = 0; m_err = 0; m_vld = 0; m_clr = 1;
    end else begin
      snd = m_pend && m_wt == 0 && m_cred > 0;
      chk("rdy", in_rdy, !m_pend);
      chk("en", mac_en, !m_pend && m_half && in_vld);
      if (mac_en) chk("mac_a", mac_a, m_q);
      chk("clr", mac_clr, m_clr || snd);
      chk("en_clr_excl", mac_en && mac_clr, 0);
      chk("vld", out_vld, m_vld);
      if (out_vld) begin
        chk("score", out_score, m_score);
        got.push_back(out_score);
        got_cyc.push_back(cyc);
      end
      chk("cred", credits, m_cred);
      chk("err", credit_err, m_err);
      // advance to the next cycle
      p0 = m_pend;
      m_clr = 0;
      m_vld = 0;
      if (snd) begin
        m_vld = 1;
        m_score = model_score(m_psum);
        m_pend = 0;
      end else if (m_pend && m_wt > 0) begin
        m_wt--;
      end
      if (snd && !credit_ret) m_cred--;
      else if (!snd && credit_ret) begin
        if (m_cred == CR) m_err = 1;
        else m_cred++;
      end
      if (!p0 && in_vld) begin
        if (!m_half) begin
          m_q = in_data;
          m_half = 1;
        end else begin
          m_sum += $signed(m_q[7:0]) * $signed(in_data);
          m_half = 0;
          m_cnt++;
          if (m_cnt == NF) begin
            m_pend = 1;
            m_wt = 1;
            m_cnt = 0;
            m_psum = m_sum;
            m_sum = 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input int gap);
    bit ok;
    int n;
    repeat (gap) step();
    in_vld = 1'b1;
    in_data = d;
    n = 0;
    ok = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_rdy;
      if (ok) last_k_cyc = cyc;
      step();
      n++;
    end
    if (!ok) chk("put_timeout", 0, 1);
    in_vld = 1'b0;
  endtask

  task automatic run(input logic [7:0] qs[4],
                     input logic [7:0] ks[4],
                     input int gap);
    for (int i = 0; i < NF; i++) begin
      put(qs[i], gap);
      put(ks[i], gap);
    end
  endtask

  task automatic wait_n(input int n);
    int t = 0;
    while (got.size() < n && t < 100) begin
      step();
      t++;
    end
    chk("wait_vld", got.size(), n);
  endtask

  task automatic ret();
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
  endtask

  logic [7:0] qa[4], ka[4], qm[4], km[4], qx[4];
  int e_40, e_7f, e_mx, base;

  initial begin
    qa = '{8'h40, 8'h40, 8'h40, 8'h40};
    ka = '{8'h40, 8'h40, 8'h40, 8'h40};
    qx = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
    qm = '{8'h10, 8'hF0, 8'h7F, 8'h05};
    km = '{8'h20, 8'h30, 8'h80, 8'h05};
`ifdef ATTN_SCORE_SAT_EN
    e_40 = 'h40; e_7f = 'h7F; e_mx = 'hBF;
`else
    e_40 = 'h20; e_7f = 'h7E; e_mx = 'hDF;
`endif
    // pin the model with hand-computed values
    chk("model_40", model_score(16384), e_40);
    chk("model_7f", model_score(64516), e_7f);
    chk("model_mx", model_score(-16487), e_mx);

    rst_n = 1'b0;
    in_vld = 1'b0;
    in_data = '0;
    credit_ret = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    chk("r_cred", credits, 2);
    chk("r_score", out_score, 0);

    // 1: basic score and latency
    run(qa, ka, 0);
    wait_n(1);
    chk("t1_score", got[0], e_40);
    chk("t1_lat", got_cyc[0] - last_k_cyc, 3);
    ret();

    // 2: large products
    run(qx, qx, 0);
    wait_n(2);
    chk("t2_score", got[1], e_7f);
    ret();
    chk("t2_cred", credits, 2);

    // 3: exhaust credits, stall in SEND
    base = got.size();
    run(qa, ka, 0);
    run(qa, ka, 0);
    run(qa, ka, 0);
    repeat (10) step();
    chk("t3_sent", got.size() - base, 2);
    chk("t3_rdy", in_rdy, 0);
    chk("t3_cred", credits, 0);
    ret();
    wait_n(base + 3);
    chk("t3_score", got[base + 2], e_40);
    ret();
    chk("t3_cred1", credits, 1);

    // 4: return during send, then overflow return
    base = got.size();
    run(qa, ka, 0);
    step();
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    wait_n(base + 1);
    chk("t4_cred", credits, 1);
    ret();
    chk("t4_cred2", credits, 2);
    chk("t4_noerr", credit_err, 0);
    ret();
    chk("t4_err", credit_err, 1);
    chk("t4_cred3", credits, 2);

    // 5: gaps give the same result
    base = got.size();
    run(qm, km, 0);
    wait_n(base + 1);
    chk("t5_nogap", got[base], e_mx);
    ret();
    run(qm, km, 2);
    wait_n(base + 2);
    chk("t5_gap", got[base + 1], e_mx);
    chk("t5_same", got[base + 1], got[base]);
    ret();

    // 6: reset mid-score
    for (int i = 0; i < 2; i++) begin
      put(qx[i], 0);
      put(qx[i], 0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_score", out_score, 0);
    chk("t6_err", credit_err, 0);
    chk("t6_cred", credits, 2);
    chk("t6_vld", out_vld, 0);
    chk("t6_clr", mac_clr, 0);
    chk("t6_en", mac_en, 0);
    step();
    step();
    rst_n = 1'b1;
    base = got.size();
    run(qa, ka, 0);
    wait_n(base + 1);
    chk("t6_clean", got[base], e_40);
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
